// File: rtl/bcd_led_scan_pkg.sv
// -----------------------------------------------------------------------------
// bcd_led_scan_pkg
//   Shared definitions for the bcd_led_scan display driver:
//   - 7-segment patterns, bit order {a,b,c,d,e,f,g,dp}, active-high
//   - FSM state encoding for the conversion controller
// -----------------------------------------------------------------------------
package bcd_led_scan_pkg;

  // Segment patterns for decimal digits.
  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;

  // Overflow indicator: only the middle bar (g) lit.
  localparam logic [7:0] SEG_DASH  = 8'b0000_0010;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  // Conversion FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } state_e;

endpackage : bcd_led_scan_pkg

// File: rtl/seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
//   Combinational BCD nibble to 7-segment pattern decoder.
//   Ports:
//     bcd  in  4  BCD digit; codes 10..15 decode to an unlit digit
//     seg  out 8  segments {a,b,c,d,e,f,g,dp}, active-high
// -----------------------------------------------------------------------------
module seg7_encode
  import bcd_led_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      // Non-BCD codes show nothing rather than garbage.
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : seg7_encode

// File: rtl/bcd_led_scan.sv
// -----------------------------------------------------------------------------
// bcd_led_scan
//   Binary to multiplexed 7-segment display driver. A binary value accepted
//   on a valid/ready handshake is converted to BCD by a sequential
//   double-dabble engine (one input bit per clock). The result is shown on a
//   common-segment LED bank, one digit at a time, with optional leading-zero
//   blanking and a dash pattern when the value does not fit in DIGITS digits.
//
//   Parameters:
//     IN_W      binary input width (1..32)
//     DIGITS    number of BCD digits / LED positions (1..10)
//     SCAN_DIV  clocks each digit stays selected (>=1)
//     BLANK_LZ  1 = blank leading zeros (digit 0 is never blanked)
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous reset, active-high; forces all outputs to 0
//     in_valid   in   in_data valid
//     in_data    in   unsigned binary value, IN_W bits
//     in_ready   out  block idle and able to accept in_data
//     bcd_out    out  last converted BCD value, digit 0 in [3:0]
//     bcd_valid  out  one-cycle pulse: bcd_out / overflow just updated
//     overflow   out  last value >= 10**DIGITS, held until next bcd_valid
//     seg        out  segments {a,b,c,d,e,f,g,dp}, active-high
//     dig_sel    out  one-hot digit enable, bit i = digit i
// -----------------------------------------------------------------------------
module bcd_led_scan
  import bcd_led_scan_pkg::*;
#(
  parameter int IN_W     = 28,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  overflow,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [IN_W-1:0]    shreg_q,  shreg_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  // Result / display registers
  logic [ACC_W-1:0]   bcd_q,    bcd_d;
  logic               ovf_q,    ovf_d;
  logic               valid_q,  valid_d;
  logic [ACC_W-1:0]   disp_q,   disp_d;

  // Scan state
  logic [PS_W-1:0]    ps_q,     ps_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [7:0]         seg_q,    seg_d;
  logic [DIGITS-1:0]  dsel_q,   dsel_d;

  // Double-dabble helper: accumulator with every nibble >= 5 corrected by +3.
  logic [ACC_W-1:0]   adj;

  // Scan helpers
  logic [3:0]         nibble;
  logic               upper_zero;
  logic [7:0]         enc_seg;

  // ---------------------------------------------------------------------------
  // Conversion FSM and double-dabble datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    disp_d   = disp_q;
    valid_d  = 1'b0;

    adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d  = in_data;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(IN_W);
          state_d  = ST_CONV;
        end
      end

      ST_CONV: begin
        // Shift {ovf_bit, acc, shreg} left by one; the bit falling out of the
        // accumulator top means the value no longer fits in DIGITS digits.
        acc_d    = {adj[ACC_W-2:0], shreg_q[IN_W-1]};
        shreg_d  = shreg_q << 1;
        sticky_d = sticky_q | adj[ACC_W-1];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Results are latched on the edge into DONE so that bcd_out,
          // overflow and the display register are already valid during the
          // DONE cycle in which bcd_valid is high.
          state_d = ST_DONE;
          bcd_d   = acc_d;
          ovf_d   = sticky_d;
          disp_d  = acc_d;
          valid_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan counter and digit multiplexer
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble     = '0;
    upper_zero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble     = disp_q[4*k +: 4];
        // Digit k is a leading zero when it and every digit above it are 0.
        upper_zero = ((disp_q >> (4*k)) == '0);
      end
    end
  end

  seg7_encode u_seg7_encode (
    .bcd (nibble),
    .seg (enc_seg)
  );

  always_comb begin
    ps_d  = ps_q + PS_W'(1);
    idx_d = idx_q;
    if (ps_q == PS_W'(SCAN_DIV - 1)) begin
      ps_d  = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    seg_d = enc_seg;
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if ((BLANK_LZ != 0) && (idx_q != '0) && upper_zero) begin
      seg_d = SEG_BLANK;
    end

    dsel_d = DIGITS'(1) << idx_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      disp_q   <= '0;
      ps_q     <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      dsel_q   <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      disp_q   <= disp_d;
      ps_q     <= ps_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dsel_q   <= dsel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: held at 0 for the whole time rst is high, including the cycle
  // before the reset edge has cleared the registers.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign bcd_out   = rst ? '0 : bcd_q;
  assign bcd_valid = valid_q && !rst;
  assign overflow  = ovf_q && !rst;
  assign seg       = rst ? '0 : seg_q;
  assign dig_sel   = rst ? '0 : dsel_q;

endmodule : bcd_led_scan

// File: tb/tb_bcd_led_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_led_scan
//   Self-checking bench for bcd_led_scan (IN_W=28, DIGITS=8, SCAN_DIV=4).
//   Expected values come from a decimal model (div/mod by powers of ten).
// -----------------------------------------------------------------------------
module tb_bcd_led_scan;

  localparam int IN_W     = 28;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;
  localparam int BLANK_LZ = 1;
  localparam int ACC_W    = 4 * DIGITS;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [IN_W-1:0]    in_data;
  logic               in_ready;
  logic [ACC_W-1:0]   bcd_out;
  logic               bcd_valid;
  logic               overflow;
  logic [7:0]         seg;
  logic [DIGITS-1:0]  dig_sel;

  int checks = 0;
  int errors = 0;

  // Model of what the display should show.
  longint exp_val = 0;   // displayed value modulo 10**DIGITS
  bit     exp_ovf = 1'b0;

  bcd_led_scan #(
    .IN_W     (IN_W),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (BLANK_LZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .overflow  (overflow),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic longint pow10(int n);
    longint r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [ACC_W-1:0] to_bcd(longint v);
    logic [ACC_W-1:0] r = '0;
    longint x = v % pow10(DIGITS);
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_pattern(longint d);
    case (d)
      0: return 8'b11111100;
      1: return 8'b01100000;
      2: return 8'b11011010;
      3: return 8'b11110010;
      4: return 8'b01100110;
      5: return 8'b10110110;
      6: return 8'b10111110;
      7: return 8'b11100000;
      8: return 8'b11111110;
      9: return 8'b11110110;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] expect_seg(int i);
    if (exp_ovf) return 8'b00000010;
    if (BLANK_LZ != 0 && i > 0 && exp_val < pow10(i)) return 8'h00;
    return digit_pattern((exp_val / pow10(i)) % 10);
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_val = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: in_ready=%b expected 1", name, in_ready);
    end
  endtask

  // Send one value, check latency, result and the return to idle.
  task automatic convert(input longint v, input string name);
    int edges;
    logic [ACC_W-1:0] exp_bcd;
    bit ovf;
    wait_ready(name);
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    while (!bcd_valid && edges < IN_W + 20) begin
      @(negedge clk);
      edges++;
    end
    exp_bcd = to_bcd(v);
    ovf     = (v >= pow10(DIGITS));
    checks++;
    if (bcd_valid !== 1'b1 || edges != IN_W + 1) begin
      errors++;
      $display("FAIL %s_latency: bcd_valid=%b after %0d cycles expected 1 after %0d",
               name, bcd_valid, edges, IN_W + 1);
    end
    checks++;
    if (bcd_out !== exp_bcd) begin
      errors++;
      $display("FAIL %s_bcd: got %h expected %h", name, bcd_out, exp_bcd);
    end
    checks++;
    if (overflow !== ovf) begin
      errors++;
      $display("FAIL %s_ovf: got %b expected %b", name, overflow, ovf);
    end
    exp_val = v % pow10(DIGITS);
    exp_ovf = ovf;
    @(negedge clk);
    checks++;
    if (bcd_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_pulse: bcd_valid=%b in_ready=%b expected 0/1",
               name, bcd_valid, in_ready);
    end
  endtask

  // Watch one full scan period: one-hot select and the model's pattern per digit.
  task automatic check_display(input string name);
    logic [DIGITS-1:0] seen = '0;
    int idx;
    logic [7:0] exp_s;
    repeat (2) @(negedge clk);
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      @(negedge clk);
      checks++;
      if (!$onehot(dig_sel)) begin
        errors++;
        $display("FAIL %s_onehot: dig_sel=%b expected one-hot", name, dig_sel);
      end else begin
        idx = 0;
        for (int k = 0; k < DIGITS; k++) if (dig_sel[k]) idx = k;
        exp_s = expect_seg(idx);
        seen[idx] = 1'b1;
        checks++;
        if (seg !== exp_s) begin
          errors++;
          $display("FAIL %s_seg%0d: got %b expected %b", name, idx, seg, exp_s);
        end
      end
    end
    checks++;
    if (seen !== {DIGITS{1'b1}}) begin
      errors++;
      $display("FAIL %s_coverage: digits seen %b expected all", name, seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, bcd_valid, overflow} !== 3'b000 || bcd_out !== '0 ||
        seg !== 8'h00 || dig_sel !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b ovf=%b bcd=%h seg=%b sel=%b expected all 0",
               in_ready, bcd_valid, overflow, bcd_out, seg, dig_sel);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dig_sel !== 8'h01) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b dig_sel=%b expected 1/00000001",
               in_ready, dig_sel);
    end
  endtask

  // Scan order from reset: digit ((n-1)/SCAN_DIV) mod DIGITS after n clocks.
  task automatic test_scan();
    logic [DIGITS-1:0] exp_sel;
    int d;
    apply_reset();
    for (int n = 1; n <= 2 * DIGITS * SCAN_DIV + 2; n++) begin
      @(negedge clk);
      d = ((n - 1) / SCAN_DIV) % DIGITS;
      exp_sel = '0;
      exp_sel[d] = 1'b1;
      checks++;
      if (dig_sel !== exp_sel || seg !== expect_seg(d)) begin
        errors++;
        $display("FAIL scan_n%0d: dig_sel=%b seg=%b expected %b/%b",
                 n, dig_sel, seg, exp_sel, expect_seg(d));
      end
    end
  endtask

  task automatic test_zero();
    convert(0, "zero");
    check_display("zero");
  endtask

  task automatic test_max();
    convert(99_999_999, "max");
    check_display("max");
  endtask

  task automatic test_overflow();
    convert(100_000_000, "ovf");
    check_display("ovf");
    convert(5, "after_ovf");
    check_display("after_ovf");
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    logic [ACC_W-1:0] got = '0;
    wait_ready("busy");
    in_valid = 1'b1;
    in_data  = IN_W'(1234);
    @(posedge clk);
    @(negedge clk);
    for (int e = 1; e <= IN_W + 12; e++) begin
      if (e >= 3 && e <= 10) begin
        in_valid = 1'b1;
        in_data  = IN_W'(5678);
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready_c%0d: in_ready=%b expected 0", e, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      if (bcd_valid === 1'b1) begin
        pulses++;
        got = bcd_out;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 1 || got !== to_bcd(1234)) begin
      errors++;
      $display("FAIL busy_result: %0d pulses value %h expected 1 pulse value %h",
               pulses, got, to_bcd(1234));
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_idle: in_ready=%b expected 1", in_ready);
    end
    exp_val = 1234;
    exp_ovf = 1'b0;
    check_display("busy");
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    wait_ready("abort");
    in_valid = 1'b1;
    in_data  = IN_W'(4321);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, bcd_valid, overflow} !== 3'b000 || bcd_out !== '0 ||
        seg !== 8'h00 || dig_sel !== '0) begin
      errors++;
      $display("FAIL abort_rst_outputs: rdy=%b vld=%b ovf=%b bcd=%h seg=%b sel=%b expected all 0",
               in_ready, bcd_valid, overflow, bcd_out, seg, dig_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_val = 0;
    exp_ovf = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready: in_ready=%b expected 1", in_ready);
    end
    for (int c = 0; c < IN_W + 5; c++) begin
      if (bcd_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0 || bcd_out !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL abort_result: %0d pulses bcd=%h ovf=%b expected 0 pulses bcd=0 ovf=0",
               pulses, bcd_out, overflow);
    end
    check_display("abort");
  endtask

  task automatic test_random();
    longint v;
    for (int t = 0; t < 8; t++) begin
      case (t % 3)
        0:       v = longint'($urandom_range(0, 99_999_999));
        1:       v = longint'($urandom & 32'h0FFF_FFFF);
        default: v = longint'($urandom_range(0, 9999));
      endcase
      convert(v, $sformatf("rand%0d", t));
      if (t < 3) check_display($sformatf("rand%0d", t));
    end
  endtask

  task automatic test_back_to_back();
    // Accept each value at the first ready cycle after the previous result.
    convert(1, "b2b_a");
    convert(10_000_000, "b2b_b");
    convert(90_000_009, "b2b_c");
    check_display("b2b_c");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_scan();
    test_max();
    test_overflow();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bcd_led_scan
